// File: rtl/ocp_port_arbiter.sv
// rtl/ocp_port_arbiter.sv - round-robin arbiter sharing one OCP master among NUM_REQ AXI-lite slave ports
// Optional command/response watchdog enabled by defining OCP_ARB_TIMEOUT_EN.
module ocp_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    s_awvalid,
    input  logic [NUM_REQ*AW-1:0] s_awaddr,
    output logic [NUM_REQ-1:0]    s_awready,
    input  logic [NUM_REQ-1:0]    s_wvalid,
    input  logic [NUM_REQ*DW-1:0] s_wdata,
    output logic [NUM_REQ-1:0]    s_wready,
    output logic [NUM_REQ-1:0]    s_bvalid,
    output logic [2*NUM_REQ-1:0]  s_bresp,
    input  logic [NUM_REQ-1:0]    s_bready,
    input  logic [NUM_REQ-1:0]    s_arvalid,
    input  logic [NUM_REQ*AW-1:0] s_araddr,
    output logic [NUM_REQ-1:0]    s_arready,
    output logic [NUM_REQ-1:0]    s_rvalid,
    output logic [NUM_REQ*DW-1:0] s_rdata,
    output logic [2*NUM_REQ-1:0]  s_rresp,
    input  logic [NUM_REQ-1:0]    s_rready,
    output logic [2:0]            ocp_mcmd,
    output logic [AW-1:0]         ocp_maddr,
    output logic [DW-1:0]         ocp_mdata,
    input  logic                  ocp_scmdaccept,
    input  logic [1:0]            ocp_sresp,
    input  logic [DW-1:0]         ocp_sdata,
    output logic                  ocp_mrespaccept
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_CMD, S_RESP, S_RET} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      resp_q, resp_d;

    logic [NUM_REQ-1:0] wr_elig, elig;
    logic [IW-1:0]      pick;
    logic               found;
    logic               wd_hit;

`ifdef OCP_ARB_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    assign wd_hit = (wd_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_hit = 1'b0;
`endif

    assign wr_elig = s_awvalid & s_wvalid;
    assign elig    = wr_elig | s_arvalid;

    // Descending scan so the last hit is the first eligible index after rr_q.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (elig[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;
`ifdef OCP_ARB_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        s_awready       = '0;
        s_wready        = '0;
        s_arready       = '0;
        s_bvalid        = '0;
        s_bresp         = '0;
        s_rvalid        = '0;
        s_rdata         = '0;
        s_rresp         = '0;
        ocp_mcmd        = 3'd0;
        ocp_maddr       = '0;
        ocp_mdata       = '0;
        ocp_mrespaccept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    wr_d    = wr_elig[pick];
                    addr_d  = wr_elig[pick] ? s_awaddr[pick*AW +: AW] : s_araddr[pick*AW +: AW];
                    data_d  = wr_elig[pick] ? s_wdata[pick*DW +: DW] : '0;
                    resp_d  = 2'b00;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (wr_q) begin
                    s_awready[gnt_q] = 1'b1;
                    s_wready[gnt_q]  = 1'b1;
                end else begin
                    s_arready[gnt_q] = 1'b1;
                end
`ifdef OCP_ARB_TIMEOUT_EN
                wd_d = '0;
`endif
                state_d = S_CMD;
            end
            S_CMD: begin
                ocp_mcmd  = wr_q ? 3'd1 : 3'd2;
                ocp_maddr = addr_q;
                ocp_mdata = data_q;
                if (ocp_scmdaccept) begin
                    if (wr_q) begin
                        resp_d  = 2'b00;
                        state_d = S_RET;
                    end else begin
`ifdef OCP_ARB_TIMEOUT_EN
                        wd_d = '0;
`endif
                        state_d = S_RESP;
                    end
                end else if (wd_hit) begin
                    resp_d  = 2'b10;
                    data_d  = '0;
                    state_d = S_RET;
                end else begin
`ifdef OCP_ARB_TIMEOUT_EN
                    wd_d = wd_q + 32'd1;
`endif
                end
            end
            S_RESP: begin
                ocp_mrespaccept = 1'b1;
                if (ocp_sresp == 2'd1) begin
                    data_d  = ocp_sdata;
                    resp_d  = 2'b00;
                    state_d = S_RET;
                end else if (ocp_sresp == 2'd3) begin
                    data_d  = ocp_sdata;
                    resp_d  = 2'b10;
                    state_d = S_RET;
                end else if (wd_hit) begin
                    data_d  = '0;
                    resp_d  = 2'b10;
                    state_d = S_RET;
                end else begin
`ifdef OCP_ARB_TIMEOUT_EN
                    wd_d = wd_q + 32'd1;
`endif
                end
            end
            S_RET: begin
                if (wr_q) begin
                    s_bvalid[gnt_q]           = 1'b1;
                    s_bresp[gnt_q*2 +: 2]     = resp_q;
                    if (s_bready[gnt_q]) begin
                        rr_d    = gnt_q;
                        state_d = S_IDLE;
                    end
                end else begin
                    s_rvalid[gnt_q]           = 1'b1;
                    s_rresp[gnt_q*2 +: 2]     = resp_q;
                    s_rdata[gnt_q*DW +: DW]   = data_q;
                    if (s_rready[gnt_q]) begin
                        rr_d    = gnt_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= 2'b00;
`ifdef OCP_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
`ifdef OCP_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end
endmodule

// File: tb/tb_ocp_port_arbiter.sv
// tb/tb_ocp_port_arbiter.sv - directed self-checking bench for ocp_port_arbiter (two requesters)
module tb_ocp_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_bresp, s_rresp;
    logic [2:0]  ocp_mcmd;
    logic [31:0] ocp_maddr, ocp_mdata, ocp_sdata;
    logic        ocp_scmdaccept, ocp_mrespaccept;
    logic [1:0]  ocp_sresp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ocp_port_arbiter #(.NUM_REQ(2), .AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .ocp_mcmd(ocp_mcmd), .ocp_maddr(ocp_maddr), .ocp_mdata(ocp_mdata),
        .ocp_scmdaccept(ocp_scmdaccept), .ocp_sresp(ocp_sresp), .ocp_sdata(ocp_sdata),
        .ocp_mrespaccept(ocp_mrespaccept)
    );

    task automatic test_reset;
        rst = 1'b1;
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        s_bready = 2'b11; s_rready = 2'b11;
        ocp_scmdaccept = 1'b1; ocp_sresp = 2'd0; ocp_sdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (ocp_mcmd !== 3'd0) begin errors++; $display("FAIL reset_mcmd: got %0d expected 0", ocp_mcmd); end
        checks++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 10'd0) begin errors++; $display("FAIL reset_hs: got %h expected 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}); end
        checks++; if ({ocp_maddr, ocp_mdata, ocp_mrespaccept} !== 65'd0) begin errors++; $display("FAIL reset_ocp: got %h expected 0", {ocp_maddr, ocp_mdata, ocp_mrespaccept}); end
        rst = 1'b0;
    endtask

    task automatic test_write;
        @(negedge clk);
        s_awvalid = 2'b01; s_wvalid = 2'b01; s_awaddr[31:0] = 32'h100; s_wdata[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({s_awready, s_wready} !== 4'b0101) begin errors++; $display("FAIL wr_ready: got %b expected 0101", {s_awready, s_wready}); end
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        checks++; if (ocp_mcmd !== 3'd1) begin errors++; $display("FAIL wr_mcmd: got %0d expected 1", ocp_mcmd); end
        checks++; if (ocp_maddr !== 32'h100) begin errors++; $display("FAIL wr_maddr: got %h expected 100", ocp_maddr); end
        checks++; if (ocp_mdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mdata: got %h expected deadbeef", ocp_mdata); end
        @(negedge clk);
        checks++; if (s_bvalid !== 2'b01 || s_bresp !== 4'b0000) begin errors++; $display("FAIL wr_bresp: got bvalid=%b bresp=%b expected 01/0000", s_bvalid, s_bresp); end
        @(negedge clk);
        checks++; if (s_bvalid !== 2'b00) begin errors++; $display("FAIL wr_bdone: got %b expected 00", s_bvalid); end
    endtask

    task automatic test_read;
        @(negedge clk);
        s_arvalid = 2'b10; s_araddr[63:32] = 32'h200;
        @(negedge clk);
        checks++; if (s_arready !== 2'b10) begin errors++; $display("FAIL rd_arready: got %b expected 10", s_arready); end
        @(negedge clk);
        s_arvalid = '0;
        checks++; if (ocp_mcmd !== 3'd2 || ocp_maddr !== 32'h200 || ocp_mdata !== 32'd0) begin errors++; $display("FAIL rd_cmd: got %0d/%h/%h expected 2/200/0", ocp_mcmd, ocp_maddr, ocp_mdata); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ocp_mrespaccept !== 1'b1) begin errors++; $display("FAIL rd_mrespaccept%0d: got %b expected 1", c, ocp_mrespaccept); end
        end
        ocp_sresp = 2'd1; ocp_sdata = 32'h12345678;
        @(negedge clk);
        ocp_sresp = 2'd0; ocp_sdata = '0;
        checks++; if (s_rvalid !== 2'b10 || s_rresp !== 4'b0000) begin errors++; $display("FAIL rd_rvalid: got %b/%b expected 10/0000", s_rvalid, s_rresp); end
        checks++; if (s_rdata[63:32] !== 32'h12345678) begin errors++; $display("FAIL rd_rdata: got %h expected 12345678", s_rdata[63:32]); end
        @(negedge clk);
        checks++; if (s_rvalid !== 2'b00) begin errors++; $display("FAIL rd_rdone: got %b expected 00", s_rvalid); end
    endtask

    task automatic test_round_robin;
        logic [1:0] got [4];
        logic [1:0] exp_order [4];
        int n = 0;
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        @(negedge clk);
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_awaddr = {32'h1004, 32'h1000}; s_wdata = {32'hBBBB, 32'hAAAA};
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (s_awready != 2'b00) begin got[n] = s_awready; n++; end
        end
        s_awvalid = '0; s_wvalid = '0;
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] !== exp_order[i]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, got[i], exp_order[i]); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_then_read;
        @(negedge clk);
        s_awvalid = 2'b01; s_wvalid = 2'b01; s_arvalid = 2'b01;
        s_awaddr[31:0] = 32'h300; s_wdata[31:0] = 32'h55; s_araddr[31:0] = 32'h400;
        @(negedge clk);
        checks++; if (s_awready !== 2'b01 || s_arready !== 2'b00) begin errors++; $display("FAIL wr_first: got aw=%b ar=%b expected 01/00", s_awready, s_arready); end
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        checks++; if (ocp_mcmd !== 3'd1 || ocp_maddr !== 32'h300) begin errors++; $display("FAIL wr_first_cmd: got %0d/%h expected 1/300", ocp_mcmd, ocp_maddr); end
        @(negedge clk);
        checks++; if (s_bvalid !== 2'b01) begin errors++; $display("FAIL wr_first_b: got %b expected 01", s_bvalid); end
        repeat (2) @(negedge clk);
        checks++; if (s_arready !== 2'b01) begin errors++; $display("FAIL rd_next_ar: got %b expected 01", s_arready); end
        @(negedge clk);
        s_arvalid = '0;
        checks++; if (ocp_mcmd !== 3'd2 || ocp_maddr !== 32'h400) begin errors++; $display("FAIL rd_next_cmd: got %0d/%h expected 2/400", ocp_mcmd, ocp_maddr); end
        @(negedge clk);
        ocp_sresp = 2'd3; ocp_sdata = 32'hBAD;
        @(negedge clk);
        ocp_sresp = 2'd0; ocp_sdata = '0;
        checks++; if (s_rvalid !== 2'b01 || s_rresp !== 4'b0010) begin errors++; $display("FAIL rd_err_resp: got %b/%b expected 01/0010", s_rvalid, s_rresp); end
        checks++; if (s_rdata[31:0] !== 32'hBAD) begin errors++; $display("FAIL rd_err_data: got %h expected bad", s_rdata[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ocp_scmdaccept = 1'b0;
        s_awvalid = 2'b10; s_wvalid = 2'b10; s_awaddr[63:32] = 32'h500;
        @(negedge clk);
        checks++; if (s_awready !== 2'b10) begin errors++; $display("FAIL rm_ready: got %b expected 10", s_awready); end
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        checks++; if (ocp_mcmd !== 3'd1) begin errors++; $display("FAIL rm_mcmd: got %0d expected 1", ocp_mcmd); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ocp_scmdaccept = 1'b1;
        checks++; if (ocp_mcmd !== 3'd0 || ocp_maddr !== 32'd0) begin errors++; $display("FAIL rm_idle: got %0d/%h expected 0/0", ocp_mcmd, ocp_maddr); end
        checks++; if ({s_awready, s_bvalid, s_rvalid, ocp_mrespaccept} !== 7'd0) begin errors++; $display("FAIL rm_outs: got %b expected 0", {s_awready, s_bvalid, s_rvalid, ocp_mrespaccept}); end
        s_awvalid = 2'b11; s_wvalid = 2'b11;
        @(negedge clk);
        checks++; if (s_awready !== 2'b01) begin errors++; $display("FAIL rm_regrant: got %b expected 01", s_awready); end
        s_awvalid = '0; s_wvalid = '0;
        repeat (3) @(negedge clk);
    endtask

`ifdef OCP_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int cnt = 0;
        @(negedge clk);
        ocp_scmdaccept = 1'b0;
        s_awvalid = 2'b10; s_wvalid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        for (int c = 0; c < 20; c++) begin
            if (ocp_mcmd == 3'd1) cnt++;
            else break;
            @(negedge clk);
        end
        checks++; if (cnt != 8) begin errors++; $display("FAIL to_cycles: got %0d expected 8", cnt); end
        checks++; if (s_bvalid !== 2'b10 || s_bresp !== 4'b1000) begin errors++; $display("FAIL to_bresp: got %b/%b expected 10/1000", s_bvalid, s_bresp); end
        ocp_scmdaccept = 1'b1;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_write_then_read();
        test_reset_mid();
`ifdef OCP_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
